// File: rtl/bb_sequencer_pkg.sv
// bb_sequencer_pkg
//   Shared definitions for the bus sequencer: unit-enable bit indices,
//   opcode constants, fault codes, FSM state encoding and a one-hot helper.
//   No ports (package).
package bb_sequencer_pkg;

  localparam int NUM_UNITS = 16;

  // Bit positions in the ien/oen buses
  localparam logic [3:0] INDEX_EN_NULL     = 4'd0;
  localparam logic [3:0] INDEX_EN_IR       = 4'd1;
  localparam logic [3:0] INDEX_EN_PC       = 4'd2;
  localparam logic [3:0] INDEX_EN_AR       = 4'd3;
  localparam logic [3:0] INDEX_EN_DR0      = 4'd4;
  localparam logic [3:0] INDEX_EN_DR1      = 4'd5;
  localparam logic [3:0] INDEX_EN_CR       = 4'd6;
  localparam logic [3:0] INDEX_EN_DR2      = 4'd7;
  localparam logic [3:0] INDEX_EN_SKIN_PC  = 4'd12;
  localparam logic [3:0] INDEX_EN_SKIN_AR  = 4'd13;
  localparam logic [3:0] INDEX_EN_SKIN_AUX = 4'd14;
  localparam logic [3:0] INDEX_EN_RSVD     = 4'd15;

  localparam logic [7:0] OP_MOVE = 8'h00;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_HALT
  } state_e;

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [3:0] code);
    unit_onehot = {{(NUM_UNITS-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/bb_instr_decode.sv
// bb_instr_decode
//   Combinational decode of the IR word into the sequencer's control view.
//   Ports:
//     instruction  in   16  IR value ([15:8] opcode, [7:4] src, [3:0] dst)
//     is_halt      out   1  HALT opcode
//     illegal      out   1  unknown opcode or illegal MOVE operand pair
//     needs_mem    out   1  src or dst is a skin-memory unit (12..14)
//     is_write     out   1  dst is a skin write port (13/14)
//     addr_sel     out   1  address comes from AR (src or dst is 13)
//     src, dst     out   4  unit codes
module bb_instr_decode
  import bb_sequencer_pkg::*;
(
  input  logic [15:0] instruction,
  output logic        is_halt,
  output logic        illegal,
  output logic        needs_mem,
  output logic        is_write,
  output logic        addr_sel,
  output logic [3:0]  src,
  output logic [3:0]  dst
);

  logic [7:0] opcode;
  logic       src_ok;
  logic       dst_ok;
  logic       pair_ok;

  function automatic logic is_skin(input logic [3:0] code);
    is_skin = (code == INDEX_EN_SKIN_PC) || (code == INDEX_EN_SKIN_AR) ||
              (code == INDEX_EN_SKIN_AUX);
  endfunction

  assign opcode = instruction[15:8];
  assign src    = instruction[7:4];
  assign dst    = instruction[3:0];

  assign src_ok = (src != INDEX_EN_NULL) && (src != INDEX_EN_RSVD);
  // Skin-at-PC is read-only as a destination: it is the fetch port.
  assign dst_ok = (dst != INDEX_EN_NULL) && (dst != INDEX_EN_RSVD) &&
                  (dst != INDEX_EN_SKIN_PC);
  // DR0->DR0 is the increment idiom; CR->PC (branch) already has src != dst.
  assign pair_ok = (src != dst) || (src == INDEX_EN_DR0);

  assign is_halt   = (opcode == OP_HALT);
  assign illegal   = !is_halt && !((opcode == OP_MOVE) && src_ok && dst_ok && pair_ok);
  assign needs_mem = is_skin(src) || is_skin(dst);
  assign is_write  = (dst == INDEX_EN_SKIN_AR) || (dst == INDEX_EN_SKIN_AUX);
  assign addr_sel  = (src == INDEX_EN_SKIN_AR) || (dst == INDEX_EN_SKIN_AR);

endmodule

// File: rtl/bb_sequencer.sv
// bb_sequencer
//   Control FSM driving the one-hot unit-enable buses of the core. Fetches
//   each instruction from skin memory into IR, decodes it and issues exactly
//   one bus transfer, with memory handshake, HALT, illegal-op and timeout.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     i_start          leave IDLE/HALT and start fetching
//     i_instruction    current IR value
//     i_mem_ack        skin memory ack pulse
//     o_unit_ien/oen   destination/source enables (bit = unit code)
//     o_mem_req        memory request, held until ack
//     o_mem_addr_sel   0 = PC, 1 = AR
//     o_mem_we         request is a write
//     o_halted         FSM is in HALT
//     o_fault          00 none, 01 illegal, 10 timeout (sticky until start)
module bb_sequencer
  import bb_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  input  logic                  i_mem_ack,
  output logic [15:0]           o_unit_ien,
  output logic [15:0]           o_unit_oen,
  output logic                  o_mem_req,
  output logic                  o_mem_addr_sel,
  output logic                  o_mem_we,
  output logic                  o_halted,
  output logic [1:0]            o_fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       xfer_src;
  logic [3:0]       xfer_dst;

  logic       dec_is_halt;
  logic       dec_illegal;
  logic       dec_needs_mem;
  logic       dec_is_write;
  logic       dec_addr_sel;
  logic [3:0] dec_src;
  logic [3:0] dec_dst;

  bb_instr_decode u_decode (
    .instruction (i_instruction[15:0]),
    .is_halt     (dec_is_halt),
    .illegal     (dec_illegal),
    .needs_mem   (dec_needs_mem),
    .is_write    (dec_is_write),
    .addr_sel    (dec_addr_sel),
    .src         (dec_src),
    .dst         (dec_dst)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      o_mem_req      <= 1'b0;
      o_mem_addr_sel <= 1'b0;
      o_mem_we       <= 1'b0;
      o_halted       <= 1'b0;
      o_fault        <= FAULT_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (i_start) begin
            state          <= ST_FETCH;
            wait_cnt       <= '0;
            o_mem_req      <= 1'b1;
            o_mem_addr_sel <= 1'b0;
            o_mem_we       <= 1'b0;
            o_halted       <= 1'b0;
            o_fault        <= FAULT_NONE;
          end
        end
        ST_FETCH, ST_MEM_WAIT: begin
          if (i_mem_ack) begin
            o_mem_addr_sel <= 1'b0;
            o_mem_we       <= 1'b0;
            wait_cnt       <= '0;
            if (state == ST_FETCH) begin
              state     <= ST_DECODE;
              o_mem_req <= 1'b0;
            end else begin
              // Transfer done: go straight back to fetching the next word.
              state     <= ST_FETCH;
              o_mem_req <= 1'b1;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state          <= ST_HALT;
            o_mem_req      <= 1'b0;
            o_mem_addr_sel <= 1'b0;
            o_mem_we       <= 1'b0;
            o_halted       <= 1'b1;
            o_fault        <= FAULT_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_is_halt || dec_illegal) begin
            state    <= ST_HALT;
            o_halted <= 1'b1;
            if (dec_illegal) o_fault <= FAULT_ILLEGAL;
          end else if (dec_needs_mem) begin
            state          <= ST_MEM_WAIT;
            wait_cnt       <= '0;
            o_mem_req      <= 1'b1;
            o_mem_addr_sel <= dec_addr_sel;
            o_mem_we       <= dec_is_write;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state          <= ST_FETCH;
          wait_cnt       <= '0;
          o_mem_req      <= 1'b1;
          o_mem_addr_sel <= 1'b0;
          o_mem_we       <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand codes captured at DECODE; only consumed in EXEC/MEM_WAIT.
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      xfer_src <= dec_src;
      xfer_dst <= dec_dst;
    end
  end

  // Enables follow the ack combinationally so a zero-wait memory completes
  // in the same cycle the request rises.
  always_comb begin
    o_unit_ien = '0;
    o_unit_oen = '0;
    case (state)
      ST_FETCH: begin
        if (i_mem_ack) begin
          o_unit_ien = unit_onehot(INDEX_EN_IR);
          o_unit_oen = unit_onehot(INDEX_EN_SKIN_PC);
        end
      end
      ST_EXEC: begin
        o_unit_ien = unit_onehot(xfer_dst);
        o_unit_oen = unit_onehot(xfer_src);
      end
      ST_MEM_WAIT: begin
        if (i_mem_ack) begin
          o_unit_ien = unit_onehot(xfer_dst);
          o_unit_oen = unit_onehot(xfer_src);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bb_sequencer.sv
// tb_bb_sequencer
//   Scoreboard bench for bb_sequencer: every expected bus transfer is queued
//   when its instruction is driven and popped by a negedge monitor whenever
//   the DUT raises any enable.
module tb_bb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] instruction;
  logic        mem_ack;
  logic [15:0] ien;
  logic [15:0] oen;
  logic        mem_req;
  logic        addr_sel;
  logic        mem_we;
  logic        halted;
  logic [1:0]  fault;

  always #5 clk = ~clk;

  bb_sequencer #(.DATA_WIDTH(16), .TIMEOUT(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_instruction  (instruction),
    .i_mem_ack      (mem_ack),
    .o_unit_ien     (ien),
    .o_unit_oen     (oen),
    .o_mem_req      (mem_req),
    .o_mem_addr_sel (addr_sel),
    .o_mem_we       (mem_we),
    .o_halted       (halted),
    .o_fault        (fault)
  );

  typedef struct packed {
    logic [15:0] ien;
    logic [15:0] oen;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_exp;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input logic [15:0] e_ien, input logic [15:0] e_oen);
    xfer_t x;
    x.ien = e_ien;
    x.oen = e_oen;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (ien != 16'h0 || oen != 16'h0) begin
      if (exp_q.size() == 0) begin
        chk("xfer_extra", {ien, oen}, 32'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("xfer", {ien, oen}, mon_exp);
      end
    end
  end

  // From IDLE/HALT: raise start for one cycle; lands in FETCH with fault cleared.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("start_state", {halted, fault, mem_req, addr_sel, mem_we}, {1'b0, 2'b00, 1'b1, 1'b0, 1'b0});
  endtask

  // In FETCH: hold off ack for fwait cycles, ack, then load IR. Ends in DECODE.
  task automatic do_fetch(input logic [15:0] instr, input int fwait);
    expect_xfer(16'h0002, 16'h1000);
    for (int i = 0; i < fwait; i++) begin
      mem_ack = 1'b0;
      #1;
      chk("fetch_wait", {ien, oen, 13'h0, mem_req, addr_sel, mem_we}, {32'h0, 13'h0, 3'b100});
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chk("fetch_strobe", {ien, oen}, 32'h0002_1000);
    tick();
    mem_ack     = 1'b0;
    instruction = instr;
    #1;
    chk("decode_quiet", {ien, oen, 15'h0, mem_req}, 48'h0);
  endtask

  // From DECODE: one EXEC cycle with the transfer, then back in FETCH.
  task automatic exec_reg(input logic [15:0] e_ien, input logic [15:0] e_oen);
    expect_xfer(e_ien, e_oen);
    tick();
    #1;
    chk("exec_cycle", {ien, oen}, {e_ien, e_oen});
    tick();
    #1;
    chk("refetch", {ien, oen, 13'h0, mem_req, addr_sel, mem_we}, {32'h0, 13'h0, 3'b100});
  endtask

  // From DECODE: MEM_WAIT for mwait cycles, then the ack cycle transfer.
  task automatic exec_mem(input int mwait, input logic e_asel, input logic e_we,
                          input logic [15:0] e_ien, input logic [15:0] e_oen);
    expect_xfer(e_ien, e_oen);
    tick();
    for (int i = 0; i < mwait; i++) begin
      mem_ack = 1'b0;
      #1;
      chk("mem_wait", {ien, oen, 13'h0, mem_req, addr_sel, mem_we}, {32'h0, 13'h0, 1'b1, e_asel, e_we});
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chk("mem_req_ack", {mem_req, addr_sel, mem_we}, {1'b1, e_asel, e_we});
    chk("mem_strobe", {ien, oen}, {e_ien, e_oen});
    tick();
    mem_ack = 1'b0;
    #1;
    chk("mem_refetch", {ien, oen, 13'h0, mem_req, addr_sel, mem_we}, {32'h0, 13'h0, 3'b100});
  endtask

  // From DECODE: expect HALT with the given fault.
  task automatic exec_halt(input logic [1:0] e_fault);
    tick();
    #1;
    chk("halt_state", {halted, fault, mem_req}, {1'b1, e_fault, 1'b0});
    chk("halt_quiet", {ien, oen}, 32'h0);
  endtask

  logic [15:0] illegal_tab [4] = '{16'h0154, 16'h004C, 16'h00F4, 16'h0040};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    start       = 1'b0;
    mem_ack     = 1'b0;
    instruction = 16'h0;
    repeat (3) tick();
    #1;
    chk("reset_outs", {ien, oen, 10'h0, mem_req, addr_sel, mem_we, halted, fault},
        {32'h0, 10'h0, 6'h0});
    rst_n = 1'b1;
    tick();
    #1;
    chk("idle_outs", {halted, fault, mem_req}, 4'h0);

    do_start();
    do_fetch(16'h0054, 0); exec_reg(16'h0010, 16'h0020);  // DR1 -> DR0
    do_fetch(16'h0044, 0); exec_reg(16'h0010, 16'h0010);  // DR0 increment
    do_fetch(16'h0062, 1); exec_reg(16'h0004, 16'h0040);  // CR -> PC branch
    do_fetch(16'h0012, 2); exec_reg(16'h0004, 16'h0002);  // IR -> PC
    do_fetch(16'h00D4, 0); exec_mem(5, 1'b1, 1'b0, 16'h0010, 16'h2000);
    do_fetch(16'h004D, 0); exec_mem(0, 1'b1, 1'b1, 16'h2000, 16'h0010);
    do_fetch(16'h00C4, 0); exec_mem(2, 1'b0, 1'b0, 16'h0010, 16'h1000);
    do_fetch(16'h007E, 0); exec_mem(1, 1'b0, 1'b1, 16'h4000, 16'h0080);

    do_fetch(16'h0033, 0); exec_halt(2'b01);
    for (int i = 0; i < 4; i++) begin
      do_start();
      do_fetch(illegal_tab[i], 0);
      exec_halt(2'b01);
    end
    do_start();
    do_fetch(16'hFF00, 0); exec_halt(2'b00);

    // Memory timeout during fetch
    do_start();
    n = 0;
    while (mem_req && n < 400) begin
      n++;
      tick();
      #1;
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_state", {halted, fault, mem_req}, {1'b1, 2'b10, 1'b0});
    mem_ack = 1'b1;
    #1;
    chk("late_ack_quiet", {ien, oen}, 32'h0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("late_ack_state", {halted, fault, mem_req}, {1'b1, 2'b10, 1'b0});

    // Reset in the middle of a memory transfer
    do_start();
    do_fetch(16'h00D4, 0);
    tick();
    #1;
    chk("pre_reset_req", {mem_req, addr_sel}, 2'b11);
    rst_n = 1'b0;
    tick();
    #1;
    chk("reset_mid", {ien, oen, 10'h0, mem_req, addr_sel, mem_we, halted, fault},
        {32'h0, 10'h0, 6'h0});
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    #1;
    chk("idle_ack_quiet", {ien, oen, 15'h0, mem_req}, 48'h0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("idle_stays", {halted, fault, mem_req}, 4'h0);
    do_start();
    do_fetch(16'hFF12, 0); exec_halt(2'b00);

    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
